// File: rtl/cic_pkg.sv
// Shared width/shift helpers and FSM state type for the CIC interpolator.
package cic_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cic_state_e;

  // Internal datapath width: input plus log2(RATE) growth per stage.
  function automatic int unsigned cic_width(input int unsigned in_w,
                                            input int unsigned n_stages,
                                            input int unsigned rate);
    return in_w + n_stages * $clog2(rate);
  endfunction

  // Output scaling: drop the gain of all but one integrator stage.
  function automatic int unsigned cic_shift(input int unsigned n_stages,
                                            input int unsigned rate);
    return (n_stages - 1) * $clog2(rate);
  endfunction

  localparam int unsigned CIC_SHIFT_DEFAULT = cic_shift(3, 4);

endpackage

// File: rtl/cic_interpolator_if.sv
// Sample-in / sample-out bundle of the CIC interpolator.
interface cic_interpolator_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic signed [IN_W-1:0]  x_i;
  logic                    x_valid_i;
  logic                    x_ready_o;
  logic signed [OUT_W-1:0] y_o;
  logic                    y_valid_o;
  logic                    underrun_o;

  modport master (output x_i, x_valid_i,
                  input  x_ready_o, y_o, y_valid_o, underrun_o);
  modport slave  (input  x_i, x_valid_i,
                  output x_ready_o, y_o, y_valid_o, underrun_o);
endinterface

// File: rtl/cic_integrator_stage.sv
// One registered integrator stage: accumulates its input on enabled cycles, wraps modulo 2^W.
module cic_integrator_stage #(
  parameter int unsigned W = 14
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                i_en,
  input  logic signed [W-1:0] i_data,
  output logic signed [W-1:0] o_acc
);
  logic signed [W-1:0] r_acc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   r_acc <= '0;
    else if (i_en) r_acc <= r_acc + i_data;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the input rate, zero-stuffed integrator cascade at the output rate.
// Optional CIC_INTERP_ROUND_EN: round half up before the output shift instead of flooring.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned RATE     = 4,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 8
) (
  input logic               clk_i,
  input logic               rstn_i,
  cic_interpolator_if.slave bus
);
  localparam int unsigned W     = cic_width(IN_W, N_STAGES, RATE);
  localparam int unsigned SHIFT = cic_shift(N_STAGES, RATE);
  localparam int unsigned PH_W  = $clog2(RATE);

  cic_state_e          r_state, w_state_nxt;
  logic [PH_W-1:0]     r_phase, w_phase_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_underrun, w_underrun_nxt;
  logic                w_accept, w_active, w_last;

  logic signed [W-1:0] r_dly [N_STAGES];
  logic signed [W-1:0] w_c   [N_STAGES];
  logic signed [W-1:0] w_acc;
  logic signed [W-1:0] r_comb_q;
  logic signed [W-1:0] w_int [N_STAGES+1];

  assign w_accept = bus.x_valid_i && r_ready;
  assign w_active = (r_state == ST_RUN);
  assign w_last   = (r_phase == PH_W'(RATE - 1));

  // Comb chain: c0 = x, ck = c(k-1) - d(k-1)
  always_comb begin
    w_acc = {{(W - IN_W){bus.x_i[IN_W-1]}}, bus.x_i};
    for (int k = 0; k < N_STAGES; k++) begin
      w_c[k] = w_acc;
      w_acc  = w_acc - r_dly[k];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_underrun_nxt = 1'b0;
    w_ready_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_phase_nxt = r_phase + PH_W'(1);
        if (w_last && !w_accept) begin
          w_state_nxt    = ST_IDLE;
          w_underrun_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Ready is registered, so decode it from the next state and phase.
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_phase_nxt == PH_W'(RATE - 1));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_ready    <= 1'b1;
      r_underrun <= 1'b0;
      r_comb_q   <= '0;
      for (int k = 0; k < N_STAGES; k++) r_dly[k] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_ready    <= w_ready_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_accept) begin
        r_comb_q <= w_acc;
        for (int k = 0; k < N_STAGES; k++) r_dly[k] <= w_c[k];
      end
    end
  end

  // Zero-stuffing: the comb result enters the integrators only at phase 0.
  assign w_int[0] = (r_phase == '0) ? r_comb_q : '0;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    cic_integrator_stage #(.W(W)) u_int (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .i_en   (w_active),
      .i_data (w_int[k]),
      .o_acc  (w_int[k+1])
    );
  end

  logic signed [W-1:0]     w_pre;
  logic signed [W-1:0]     w_shifted;
  logic signed [OUT_W-1:0] w_y;

`ifdef CIC_INTERP_ROUND_EN
  localparam logic signed [W-1:0] RND_BIAS = (SHIFT == 0) ? '0 : (W'(1) << (SHIFT - 1));
  assign w_pre = w_int[N_STAGES] + RND_BIAS;
`else
  assign w_pre = w_int[N_STAGES];
`endif
  assign w_shifted = w_pre >>> SHIFT;
  assign w_y       = OUT_W'(w_shifted);

  // Output alignment: valid trails its active cycle by N_STAGES+1; data captured once the last integrator settles.
  logic [N_STAGES:0]       r_vld;
  logic signed [OUT_W-1:0] r_y [N_STAGES];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vld <= '0;
      for (int k = 0; k < N_STAGES; k++) r_y[k] <= '0;
    end else begin
      r_vld  <= {r_vld[N_STAGES-1:0], w_active};
      r_y[0] <= w_y;
      for (int k = 1; k < N_STAGES; k++) r_y[k] <= r_y[k-1];
    end
  end

  assign bus.x_ready_o  = r_ready;
  assign bus.underrun_o = r_underrun;
  assign bus.y_valid_o  = r_vld[N_STAGES];
  assign bus.y_o        = r_y[N_STAGES-1];

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter N_STAGES, default 3, number of comb and integrator stages.
REQ-002 SHALL have parameter RATE, default 4, interpolation ratio, power of two, 2..16.
REQ-003 SHALL have parameter IN_W, default 8, signed input width.
REQ-004 SHALL have parameter OUT_W, default 8, signed output width.
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port x_i  in  IN_W  signed low-rate sample.
REQ-008 SHALL have port x_valid_i  in  1  sample offered.
REQ-009 SHALL have port x_ready_o  out  1  sample accepted when high with x_valid_i.
REQ-010 SHALL have port y_o  out  OUT_W  signed high-rate sample.
REQ-011 SHALL have port y_valid_o  out  1  y_o valid this cycle.
REQ-012 SHALL have port underrun_o  out  1  one-cycle pulse when no sample is offered at a frame boundary.

Function
REQ-013 SHALL define internal width W = IN_W + N_STAGES*log2(RATE), two's-complement, modular wrap in every adder.
REQ-014 SHALL run the comb chain once per accepted sample: c0 = x_i; ck = c(k-1) - d(k-1); each dk updates to ck only on accept.
REQ-015 SHALL register the final comb output into comb_q on accept.
REQ-016 SHALL count a frame phase 0..RATE-1; the integrator input is comb_q at phase 0 and zero at phases 1..RATE-1.
REQ-017 SHALL advance all integrators (i1 += u; ik += i(k-1), registered per stage) only on active cycles.
REQ-018 SHALL use FSM states IDLE and RUN; IDLE -> RUN on accept; RUN stays RUN when a sample is accepted at phase RATE-1; RUN -> IDLE otherwise.
REQ-019 SHALL drive x_ready_o high in IDLE and in RUN at phase RATE-1, low at other times.
REQ-020 SHALL treat every RUN cycle as active; IDLE cycles freeze comb, integrator and phase state.
REQ-021 SHALL assert y_valid_o exactly N_STAGES+1 cycles after each active cycle, one output per active cycle.
REQ-022 SHALL compute y_o = i_N arithmetically shifted right by (N_STAGES-1)*log2(RATE), then truncated to OUT_W.
REQ-023 SHALL pulse underrun_o for one cycle on the RUN -> IDLE transition.
REQ-024 SHALL accept a sample offered in the same cycle that IDLE is entered only from the next cycle, one cycle later.
REQ-025 SHALL give sustained back-to-back input exactly one y_valid_o per cycle with no gaps.

Reset
REQ-026 SHALL, on rstn_i low, clear all comb delays, comb_q, integrators, phase and output registers asynchronously.
REQ-027 SHALL reset to y_o=0, y_valid_o=0, underrun_o=0, FSM=IDLE, x_ready_o=1.
REQ-028 SHALL, on reset mid-frame, discard in-flight samples; the first output after release depends only on post-reset inputs.

Configuration
REQ-029 SHALL, with CIC_INTERP_ROUND_EN defined, add 2^(shift-1) before the REQ-022 shift (round half up).
REQ-030 SHALL, without CIC_INTERP_ROUND_EN, truncate (floor) as REQ-022 states, with no rounding adder.

Structure
REQ-031 SHALL place the W-width function, shift constant, and FSM state enum typedef in package cic_pkg.
REQ-032 SHALL implement one integrator stage as sub-module cic_integrator_stage, instantiated N_STAGES times via generate.
REQ-033 SHALL keep the comb chain, phase counter and FSM in cic_interpolator; RTL between 120 and 400 lines.

Verification
REQ-034 SHALL verify reset: assert rstn_i mid-run -> y_o=0, y_valid_o=0, x_ready_o=1 within the same cycle.
REQ-035 SHALL verify DC step (defaults): continuous x_i=16 -> after transient, y_o=16 on every valid cycle.
REQ-036 SHALL verify impulse: one sample 16 then zeros -> y_o sequence matches the length-10 binomial-triangle impulse response from a reference model, then zeros.
REQ-037 SHALL verify underrun: stop x_valid_i after 3 samples -> underrun_o pulses once, y_valid_o stops after 12 outputs; resuming continues the output sequence without discontinuity.
REQ-038 SHALL verify wrap: alternating x_i=127/-128 for 100 samples -> y_o matches the bit-exact model despite integrator overflow.
REQ-039 SHALL verify rounding: x_i=1 steady under each macro setting -> rounded and truncated outputs match the model (y=1 both; transient values differ).
